// File: rtl/cache_arbiter.sv
// cache_arbiter
// Shares one physical-memory port between the I-cache and D-cache miss
// paths. One requester is granted at a time; its address, write data and
// op are latched on grant, the memory request is held until pmem_resp, and
// the response is steered only to the granted cache. Every transaction is
// followed by at least one IDLE cycle.
//
// Optional feature: define CACHE_ARBITER_RR_EN for round-robin tie breaking
// (tie goes to the cache not served last). Default build uses fixed
// priority, with the D-cache winning ties.
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   i_read, i_address                 I-cache line-read request
//   i_rdata, i_resp                   I-cache read line / completion pulse
//   d_read, d_write, d_address,
//   d_wdata                           D-cache line read / writeback request
//   d_rdata, d_resp                   D-cache read line / completion pulse
//   pmem_read, pmem_write,
//   pmem_address, pmem_wdata          memory request (address/data registered)
//   pmem_rdata, pmem_resp             memory read line / completion
module cache_arbiter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              op_wr_q, op_wr_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic d_req_c;
  logic grant_d_c;
  logic grant_i_c;
  logic grant_c;

  // Grant decision, only acted upon in IDLE
  assign d_req_c = d_read | d_write;

`ifdef CACHE_ARBITER_RR_EN
  // 1 = D-cache was granted last; reset to D so the first tie goes to I
  logic last_grant_q, last_grant_d;

  assign grant_d_c = d_req_c & (~i_read | ~last_grant_q);

  always_comb begin
    last_grant_d = last_grant_q;
    if ((state_q == IDLE) && grant_c) begin
      last_grant_d = grant_d_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign grant_d_c = d_req_c;
`endif

  assign grant_i_c = i_read & ~grant_d_c;
  assign grant_c   = grant_d_c | grant_i_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d_c) begin
          state_d = SERVE_D;
        end else if (grant_i_c) begin
          state_d = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture on grant; held for the whole transaction
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_wr_d = op_wr_q;
    if ((state_q == IDLE) && grant_c) begin
      addr_d  = grant_d_c ? d_address : i_address;
      // d_write dominates an illegal simultaneous d_read
      op_wr_d = grant_d_c & d_write;
      if (grant_d_c && d_write) begin
        wdata_d = d_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_wr_q <= op_wr_d;
    end
  end

  // Output decode; responses are steered to the granted cache only
  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    unique case (state_q)
      SERVE_I: begin
        pmem_read = 1'b1;
        i_resp    = pmem_resp;
      end
      SERVE_D: begin
        pmem_read  = ~op_wr_q;
        pmem_write = op_wr_q;
        d_resp     = pmem_resp;
      end
      default: ;
    endcase
  end

  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_rdata      = pmem_rdata;
  assign d_rdata      = pmem_rdata;

`ifndef SYNTHESIS
  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write))
    else $warning("cache_arbiter: d_read and d_write both high, write issued");
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: each test pushes the grants it expects
// (owner, op, address, write data) before driving the caches; a negedge
// monitor pops an entry when a memory request starts and checks the request,
// its stability, the steered response and the IDLE bubble.
module tb_cache_arbiter;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit                is_d;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    bit                b2b;   // must start exactly in the cycle after the bubble
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   active;
  int   cyc;
  int   done_cyc;
  int   n_chk;
  int   n_pass;

  bit   mem_auto;
  int   mem_lat;
  int   busy;

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] obs,
                          input logic [LINE_W-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    return {8{a ^ 32'hA5A5_A5E5}};
  endfunction

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  // Memory model: responds mem_lat cycles after the request first appears
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    busy       = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_auto) begin
        busy = 0;
      end else if (pmem_resp) begin
        pmem_resp = 1'b0;
        busy      = 0;
      end else if (pmem_read || pmem_write) begin
        busy++;
        if (busy == mem_lat + 1) begin
          pmem_resp  = 1'b1;
          pmem_rdata = line_of(pmem_address);
        end
      end else begin
        busy = 0;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin : mon
    logic req_now;
    req_now = pmem_read | pmem_write;
    if (rst) begin
      active = 1'b0;
    end else begin
      if (!active && (cyc == done_cyc + 1))
        check_eq("bubble", LINE_W'(req_now), LINE_W'(0));
      if (req_now && !active) begin
        check_eq("grant_expected", LINE_W'(exp_q.size() != 0), LINE_W'(1));
        if (exp_q.size() != 0) begin
          cur    = exp_q.pop_front();
          active = 1'b1;
          if (cur.b2b) check_eq("b2b_grant_cycle", LINE_W'(cyc), LINE_W'(done_cyc + 2));
        end
      end
      if (active) begin
        check_eq("pmem_read", LINE_W'(pmem_read), LINE_W'(!cur.wr));
        check_eq("pmem_write", LINE_W'(pmem_write), LINE_W'(cur.wr));
        check_eq("pmem_address", LINE_W'(pmem_address), LINE_W'(cur.addr));
        if (cur.wr) check_eq("pmem_wdata", pmem_wdata, cur.wdata);
        if (pmem_resp) begin
          check_eq("i_resp", LINE_W'(i_resp), LINE_W'(!cur.is_d));
          check_eq("d_resp", LINE_W'(d_resp), LINE_W'(cur.is_d));
          if (cur.is_d) check_eq("d_rdata", d_rdata, line_of(cur.addr));
          else          check_eq("i_rdata", i_rdata, line_of(cur.addr));
          active   = 1'b0;
          done_cyc = cyc;
        end else begin
          check_eq("resp_early", LINE_W'({i_resp, d_resp}), LINE_W'(0));
        end
      end else begin
        check_eq("resp_idle", LINE_W'({i_resp, d_resp}), LINE_W'(0));
      end
    end
  end

  task automatic i_xact(input logic [ADDR_W-1:0] a);
    bit got;
    got       = 1'b0;
    i_read    = 1'b1;
    i_address = a;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      got = i_resp;
    end
    check_eq("i_xact_done", LINE_W'(got), LINE_W'(1));
    gap(1);
    i_read = 1'b0;
  endtask

  task automatic d_xact(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] wd,
                        input bit rd, input bit wr);
    bit got;
    got       = 1'b0;
    d_read    = rd;
    d_write   = wr;
    d_address = a;
    d_wdata   = wd;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      got = d_resp;
    end
    check_eq("d_xact_done", LINE_W'(got), LINE_W'(1));
    gap(1);
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  // D read held across two transactions; address moves to a1 in the bubble
  task automatic d_burst(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    bit got;
    d_read    = 1'b1;
    d_address = a0;
    for (int n = 0; n < 2; n++) begin
      got = 1'b0;
      for (int k = 0; k < 100 && !got; k++) begin
        @(negedge clk);
        got = d_resp;
      end
      check_eq("d_burst_done", LINE_W'(got), LINE_W'(1));
      gap(1);
      d_address = a1;
    end
    d_read = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin : main
    logic [LINE_W-1:0] wd;
    rst       = 1'b1;
    i_read    = 1'b0;
    i_address = '0;
    d_read    = 1'b0;
    d_write   = 1'b0;
    d_address = '0;
    d_wdata   = '0;
    mem_auto  = 1'b1;
    mem_lat   = 3;
    cyc       = 0;
    done_cyc  = -100;
    n_chk     = 0;
    n_pass    = 0;
    active    = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_pmem_read", LINE_W'(pmem_read), LINE_W'(0));
    check_eq("rst_pmem_write", LINE_W'(pmem_write), LINE_W'(0));
    check_eq("rst_pmem_address", LINE_W'(pmem_address), LINE_W'(0));
    check_eq("rst_pmem_wdata", pmem_wdata, LINE_W'(0));
    check_eq("rst_i_resp", LINE_W'(i_resp), LINE_W'(0));
    check_eq("rst_d_resp", LINE_W'(d_resp), LINE_W'(0));
    gap(1);
    rst = 1'b0;
    gap(2);

    // I read alone: exact grant and completion cycles
    mem_lat = 3;
    exp_q.push_back('{is_d: 1'b0, wr: 1'b0, addr: 32'h0000_0040, wdata: '0, b2b: 1'b0});
    i_read    = 1'b1;
    i_address = 32'h0000_0040;
    @(negedge clk);
    check_eq("t1_c0_pmem_read", LINE_W'(pmem_read), LINE_W'(0));
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_eq("t1_pmem_read_busy", LINE_W'(pmem_read), LINE_W'(1));
      check_eq("t1_i_resp_busy", LINE_W'(i_resp), LINE_W'(0));
    end
    @(negedge clk);
    wd = {32{8'hA5}};
    check_eq("t1_c4_i_resp", LINE_W'(i_resp), LINE_W'(1));
    check_eq("t1_c4_i_rdata", i_rdata, wd);
    check_eq("t1_c4_d_resp", LINE_W'(d_resp), LINE_W'(0));
    gap(1);
    i_read = 1'b0;
    @(negedge clk);
    check_eq("t1_c5_pmem_read", LINE_W'(pmem_read), LINE_W'(0));
    gap(2);

    // D write; address and data change mid-transaction must not leak
    mem_lat = 4;
    wd = {8{32'h1234_5678}};
    exp_q.push_back('{is_d: 1'b1, wr: 1'b1, addr: 32'h0000_1000, wdata: wd, b2b: 1'b0});
    fork
      d_xact(32'h0000_1000, wd, 1'b0, 1'b1);
      begin
        gap(3);
        d_address = 32'hDEAD_0000;
        d_wdata   = '1;
      end
    join
    gap(2);

    // Simultaneous I and D request
    mem_lat = 2;
`ifdef CACHE_ARBITER_RR_EN
    exp_q.push_back('{is_d: 1'b0, wr: 1'b0, addr: 32'h0000_0200, wdata: '0, b2b: 1'b0});
    exp_q.push_back('{is_d: 1'b1, wr: 1'b0, addr: 32'h0000_0300, wdata: '0, b2b: 1'b1});
`else
    exp_q.push_back('{is_d: 1'b1, wr: 1'b0, addr: 32'h0000_0300, wdata: '0, b2b: 1'b0});
    exp_q.push_back('{is_d: 1'b0, wr: 1'b0, addr: 32'h0000_0200, wdata: '0, b2b: 1'b1});
`endif
    fork
      i_xact(32'h0000_0200);
      d_xact(32'h0000_0300, '0, 1'b1, 1'b0);
    join
    gap(2);

    // I alone, then a tie: D wins in both modes (I was served last)
    mem_lat = 1;
    exp_q.push_back('{is_d: 1'b0, wr: 1'b0, addr: 32'h0000_0400, wdata: '0, b2b: 1'b0});
    i_xact(32'h0000_0400);
    gap(2);
    exp_q.push_back('{is_d: 1'b1, wr: 1'b0, addr: 32'h0000_0500, wdata: '0, b2b: 1'b0});
    exp_q.push_back('{is_d: 1'b0, wr: 1'b0, addr: 32'h0000_0600, wdata: '0, b2b: 1'b1});
    fork
      i_xact(32'h0000_0600);
      d_xact(32'h0000_0500, '0, 1'b1, 1'b0);
    join
    gap(2);

    // D held continuously while I waits
    mem_lat = 2;
    exp_q.push_back('{is_d: 1'b1, wr: 1'b0, addr: 32'h0000_0700, wdata: '0, b2b: 1'b0});
`ifdef CACHE_ARBITER_RR_EN
    exp_q.push_back('{is_d: 1'b0, wr: 1'b0, addr: 32'h0000_0800, wdata: '0, b2b: 1'b1});
    exp_q.push_back('{is_d: 1'b1, wr: 1'b0, addr: 32'h0000_0740, wdata: '0, b2b: 1'b1});
`else
    exp_q.push_back('{is_d: 1'b1, wr: 1'b0, addr: 32'h0000_0740, wdata: '0, b2b: 1'b1});
    exp_q.push_back('{is_d: 1'b0, wr: 1'b0, addr: 32'h0000_0800, wdata: '0, b2b: 1'b1});
`endif
    fork
      d_burst(32'h0000_0700, 32'h0000_0740);
      begin
        gap(1);
        i_xact(32'h0000_0800);
      end
    join
    gap(2);

    // Reset during SERVE_D; a late memory response must be dropped
    mem_auto = 1'b0;
    exp_q.push_back('{is_d: 1'b1, wr: 1'b0, addr: 32'h0000_0900, wdata: '0, b2b: 1'b0});
    d_read    = 1'b1;
    d_address = 32'h0000_0900;
    gap(2);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_pmem_read", LINE_W'(pmem_read), LINE_W'(0));
    check_eq("rst_mid_pmem_write", LINE_W'(pmem_write), LINE_W'(0));
    check_eq("rst_mid_pmem_address", LINE_W'(pmem_address), LINE_W'(0));
    d_read = 1'b0;
    gap(1);
    rst        = 1'b0;
    pmem_resp  = 1'b1;
    pmem_rdata = '1;
    @(negedge clk);
    check_eq("late_resp_d_resp", LINE_W'(d_resp), LINE_W'(0));
    check_eq("late_resp_pmem_read", LINE_W'(pmem_read), LINE_W'(0));
    gap(1);
    pmem_resp = 1'b0;
    mem_auto  = 1'b1;
    gap(1);
    mem_lat = 2;
    exp_q.push_back('{is_d: 1'b1, wr: 1'b0, addr: 32'h0000_0940, wdata: '0, b2b: 1'b0});
    d_xact(32'h0000_0940, '0, 1'b1, 1'b0);
    gap(2);

    // Illegal d_read and d_write together: write is issued
    wd = {4{64'hFEED_FACE_0BAD_F00D}};
    exp_q.push_back('{is_d: 1'b1, wr: 1'b1, addr: 32'h0000_0A00, wdata: wd, b2b: 1'b0});
    d_xact(32'h0000_0A00, wd, 1'b1, 1'b1);
    gap(4);

    check_eq("scoreboard_empty", LINE_W'(exp_q.size()), LINE_W'(0));
    check_eq("no_open_xact", LINE_W'(active), LINE_W'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
